// File: rtl/fifo_wptr_full.sv
// Write-side pointer, Gray export and full/level generation for the dual-clock FIFO.
// The read pointer crosses in through a two-flop synchroniser; full is registered and conservative.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rq_gray,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wcount,
  output logic                  wovf
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF = PW'(AF_LEVEL);

  logic [PW-1:0] wbin, wbin_next, wgray_next;
  logic [PW-1:0] rq_s1, rq_s2, rbin_s;
  logic          wacc, wfull_next;

  assign wacc       = winc & ~wfull;
  assign wbin_next  = wbin + {{(PW-1){1'b0}}, wacc};
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  // Full when the write pointer is a whole lap ahead: top two Gray bits inverted, rest equal.
  assign wfull_next = (wgray_next == {~rq_s2[PW-1:PW-2], rq_s2[PW-3:0]});

  always_comb begin
    rbin_s = '0;
    rbin_s[PW-1] = rq_s2[PW-1];
    for (int i = PW-2; i >= 0; i--) rbin_s[i] = rbin_s[i+1] ^ rq_s2[i];
  end

  assign waddr        = wbin[ADDR_WIDTH-1:0];
  assign wcount       = wbin - rbin_s;
  assign walmost_full = (wcount >= AF);

  always_ff @(posedge clk) begin
    if (rst) begin
      rq_s1     <= '0;
      rq_s2     <= '0;
      wbin      <= '0;
      wptr_gray <= '0;
      wfull     <= 1'b0;
      wovf      <= 1'b0;
    end else begin
      rq_s1     <= rq_gray;
      rq_s2     <= rq_s1;
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
      wfull     <= wfull_next;
      wovf      <= winc & wfull;
    end
  end
endmodule
